// File: rtl/message_expansion.sv
// SM3 message expansion: captures one 512-bit block and streams W_j / W'_j for
// j = 0..63 from a 16-word sliding window, one pair per clock.
module message_expansion #(
  parameter int START_LEAD = 2
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         start_in,
  input  logic [511:0] msg_block_in,
  input  logic         is_1st_msg_block_in,
  output logic         busy_out,
  output logic         cf_start_out,
  output logic         is_1st_msg_block_out,
  output logic [5:0]   index_j_out,
  output logic         word_valid_out,
  output logic [31:0]  word_expanded_out,
  output logic [31:0]  word_expanded_p_out,
  output logic         done_out
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  localparam logic [2:0] LEAD_LAST = 3'(START_LEAD - 1);

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] blk_word [16];
  logic [2:0]  lead_q, lead_d;
  logic [5:0]  j_q, j_d;
  logic        is_1st_q, is_1st_d;
  logic        busy_q, busy_d;
  logic        cf_start_q, cf_start_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [31:0] new_word;

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 5'd15) ^ rol(x, 5'd23);
  endfunction

  // Word 0 lives in the most significant bits of the block.
  for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
    assign blk_word[gi] = msg_block_in[511 - 32*gi -: 32];
  end

  // W_{j+16} from the window holding W_j..W_{j+15}.
  assign new_word = p1(win_q[0] ^ win_q[7] ^ rol(win_q[13], 5'd15))
                    ^ rol(win_q[3], 5'd7) ^ win_q[10];

  always_comb begin
    state_d  = state_q;
    lead_d   = lead_q;
    j_d      = j_q;
    is_1st_d = is_1st_q;
    done_d   = 1'b0;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d  = LOAD;
          lead_d   = 3'd0;
          is_1st_d = is_1st_msg_block_in;
          for (int i = 0; i < 16; i++) win_d[i] = blk_word[i];
        end
      end
      LOAD: begin
        if (lead_q == LEAD_LAST) begin
          state_d = EXPAND;
          j_d     = 6'd0;
        end else begin
          lead_d = lead_q + 3'd1;
        end
      end
      EXPAND: begin
        for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
        win_d[15] = new_word;
        j_d       = j_q + 6'd1;  // wraps to 0 after j=63
        if (j_q == 6'd63) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    cf_start_d = (state_q == IDLE) && (state_d == LOAD);
    valid_d    = (state_d == EXPAND);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      lead_q     <= 3'd0;
      j_q        <= 6'd0;
      is_1st_q   <= 1'b0;
      busy_q     <= 1'b0;
      cf_start_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
    end else begin
      state_q    <= state_d;
      lead_q     <= lead_d;
      j_q        <= j_d;
      is_1st_q   <= is_1st_d;
      busy_q     <= busy_d;
      cf_start_q <= cf_start_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign busy_out             = busy_q;
  assign cf_start_out         = cf_start_q;
  assign is_1st_msg_block_out = is_1st_q;
  assign index_j_out          = j_q;
  assign word_valid_out       = valid_q;
  assign done_out             = done_q;
  assign word_expanded_out    = win_q[0];
  assign word_expanded_p_out  = win_q[0] ^ win_q[4];

endmodule

// File: doc/message_expansion.md
# message_expansion

SM3 message expansion stage: accepts one padded 512-bit message block, then streams the 64 expanded word pairs W_j and W'_j to the compression function, one pair per clock, with index_j. It sits directly upstream of the compression function. It supplies that block's start, index_j, is_1st_msg_block, W and W' inputs from a 16-word sliding window, so no 68-word array is stored.

## Interface
- START_LEAD, default 2: cycles spent in LOAD between block capture and the first expanded word. This is the downstream start-to-first-round gap. Legal range 1..7.
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- start_in  input  1  block request; accepted only when busy_out=0.
- msg_block_in  input  512  padded block; word 0 is bits [511:480], word 15 is bits [31:0].
- is_1st_msg_block_in  input  1  block is the first of its message; sampled with start_in.
- busy_out  output  1  high in LOAD and EXPAND.
- cf_start_out  output  1  one-cycle pulse in the first LOAD cycle.
- is_1st_msg_block_out  output  1  registered copy of the sampled flag, held until the next accept.
- index_j_out  output  6  round index j.
- word_valid_out  output  1  high while a word pair is presented.
- word_expanded_out  output  32  W_j.
- word_expanded_p_out  output  32  W'_j = W_j ^ W_{j+4}.
- done_out  output  1  one-cycle pulse after the j=63 pair.

## Operation
- State machine has three states: IDLE, LOAD and EXPAND.
  - IDLE → LOAD on start_in. At that edge: window win[0..15] <= the 16 block words, is_1st flag captured, lead counter cleared.
  - LOAD lasts exactly START_LEAD cycles. cf_start_out is high in the first LOAD cycle only. Window holds. Then → EXPAND with j=0.
  - EXPAND lasts 64 cycles, j = 0..63.
    - Outputs: word_expanded_out = win[0], word_expanded_p_out = win[0] ^ win[4].
    - Each edge: the window shifts down one word, win[15] <= N, and j increments.
    - N = P1(win[0] ^ win[7] ^ ROL(win[13],15)) ^ ROL(win[3],7) ^ win[10], where P1(x) = x ^ ROL(x,15) ^ ROL(x,23).
  - After the j=63 edge: → IDLE, and done_out pulses in the following cycle.
- All arithmetic is 32-bit XOR and rotate only; there are no adders.
- Words generated beyond W_67 are don't-care and are never presented.
- start_in when busy_out=1 is ignored; there is no queueing.
- start_in is accepted in the same cycle done_out is high, because that cycle is IDLE.
- Outputs in IDLE and LOAD:
  - word_valid_out=0 and index_j_out=0.
  - word_expanded_out and word_expanded_p_out show the live window value (win[0] and win[0]^win[4]). Downstream must not use them unless word_valid_out=1.

## Timing
- Reset values: state IDLE, busy_out=0, cf_start_out=0, word_valid_out=0, done_out=0, index_j_out=0, is_1st_msg_block_out=0, window all zero. Therefore word_expanded_out=0 and word_expanded_p_out=0.
- Reset asserted mid-operation aborts on the next edge to the reset values, with no done_out pulse.
- Accept edge at cycle T.
  - cf_start_out is high in cycle T+1.
  - The j=0 pair is valid in cycle T+1+START_LEAD.
  - The j=63 pair is valid in cycle T+START_LEAD+64.
  - done_out is high in cycle T+START_LEAD+65.
- Block throughput: START_LEAD+65 cycles per block with back-to-back start_in.
- index_j_out, word_valid_out, busy_out, cf_start_out and done_out are registered (driven from flops).
- word_expanded_out and word_expanded_p_out are combinational from window flops only (win[0], and win[0] ^ win[4]). There is no path from any input.

## Test plan
- "abc" block: 0x61626380, fourteen zero words, 0x00000018. START_LEAD=2 → cf_start_out pulses once at T+1. W_0=0x61626380 at T+3. W_16=0x9092e200, W_17=0x00000000, W_18=0x000c0606. W'_0=0x61626380, W'_12=0x9092e200. done_out at T+67.
- Full-stream check of the "abc" block: all 64 W/W' pairs match a software SM3 model. index_j_out counts 0..63 contiguously with word_valid_out high for exactly 64 cycles.
- start_in held high continuously with two different blocks:
  - second accept happens in the done_out cycle, giving a period of 67 cycles;
  - start_in pulses during busy are ignored;
  - is_1st_msg_block_out follows each accept (1 then 0).
- Reset asserted at j=30: next cycle matches all reset values. A fresh start then produces a correct stream from j=0.
- START_LEAD=1 and START_LEAD=7 builds: first valid word at T+2 and T+8 respectively. cf_start_out is still a single pulse at T+1.
- Random 512-bit blocks (≥1000) are compared pairwise against the reference model; W' = W_j ^ W_{j+4} is checked at every j including j=60..63, which use W_64..W_67.
